// File: rtl/lbp_grid_scheduler.sv
// lbp_grid_scheduler
//   Walks the histogram compute unit (HCU) over every cell of an nx-by-ny LBP
//   grid in raster order (x fastest), one enable/finish job per cell, and
//   reports each completed cell with its linear index plus a final done pulse.
//
// Ports
//   clk, rst               : clock (rising edge), asynchronous active-low reset
//   start, abort           : grid request (sampled only when idle) / cancel
//   grid_x_num, grid_y_num : grid size, latched on an accepted start (0 -> 1)
//   hcu_enable             : HCU job request, held until hcu_finish
//   gridX_o, gridY_o       : coordinates of the current job
//   hcu_finish             : HCU job complete pulse
//   cell_valid, cell_index : per-cell completion pulse and its index y*nx+x
//   busy                   : scheduler not idle
//   done, aborted          : grid-complete / abort-acknowledge pulses
module lbp_grid_scheduler #(
  parameter int unsigned GRID_W = 4,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [GRID_W-1:0] grid_x_num,
  input  logic [GRID_W-1:0] grid_y_num,
  output logic              hcu_enable,
  output logic [GRID_W-1:0] gridX_o,
  output logic [GRID_W-1:0] gridY_o,
  input  logic              hcu_finish,
  output logic              cell_valid,
  output logic [IDX_W-1:0]  cell_index,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam logic [GRID_W-1:0] ONE_G = GRID_W'(1);
  localparam logic [IDX_W-1:0]  ONE_I = IDX_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t            state_q, state_d;
  logic [GRID_W-1:0] nx_q, nx_d, ny_q, ny_d;
  logic [GRID_W-1:0] x_q, x_d, y_q, y_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  cell_index_q, cell_index_d;
  logic              hcu_enable_q, hcu_enable_d;
  logic              cell_valid_q, cell_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              last_x, last_cell;

  always_comb begin
    state_d      = state_q;
    nx_d         = nx_q;
    ny_d         = ny_q;
    x_d          = x_q;
    y_d          = y_q;
    idx_d        = idx_q;
    cell_index_d = cell_index_q;
    cell_valid_d = 1'b0;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    last_x       = (x_q == nx_q - ONE_G);
    last_cell    = last_x && (y_q == ny_q - ONE_G);

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          nx_d    = (grid_x_num == '0) ? ONE_G : grid_x_num;
          ny_d    = (grid_y_num == '0) ? ONE_G : grid_y_num;
          x_d     = '0;
          y_d     = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // abort outranks a coincident hcu_finish: the job is dropped unreported
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (hcu_finish) begin
          cell_valid_d = 1'b1;
          cell_index_d = idx_q;
          if (last_cell) begin
            state_d = DONE;
          end else begin
            state_d = GAP;
            idx_d   = idx_q + ONE_I;
            if (last_x) begin
              x_d = '0;
              y_d = y_q + ONE_G;
            end else begin
              x_d = x_q + ONE_G;
            end
          end
        end
      end
      GAP: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (abort) begin
          aborted_d = 1'b1;
        end else begin
          done_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // registered outputs are derived from the state being entered
    hcu_enable_d = (state_d == RUN);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      nx_q         <= '0;
      ny_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      idx_q        <= '0;
      cell_index_q <= '0;
      hcu_enable_q <= 1'b0;
      cell_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      nx_q         <= nx_d;
      ny_q         <= ny_d;
      x_q          <= x_d;
      y_q          <= y_d;
      idx_q        <= idx_d;
      cell_index_q <= cell_index_d;
      hcu_enable_q <= hcu_enable_d;
      cell_valid_q <= cell_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign hcu_enable = hcu_enable_q;
  assign gridX_o    = x_q;
  assign gridY_o    = y_q;
  assign cell_valid = cell_valid_q;
  assign cell_index = cell_index_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;

endmodule

// File: doc/lbp_grid_scheduler.md
Name: lbp_grid_scheduler

Overview:
- Sequences the histogram compute unit (HCU) over every cell of an N×M LBP grid in raster order (x fastest).
- Issues one HCU job per cell using an enable/finish handshake, and emits a per-cell completion pulse with a linear cell index.
- Signals completion of the whole grid so the top-level controller can start the comparator.
- Sits between the top-level controller and the HCU; the controller only issues a single start per image.

Parameters:
- GRID_W, 4, width of the grid count/coordinate fields
- IDX_W, 8, width of the linear cell index (must hold (2^GRID_W-1)^2-1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to process a grid; sampled only in IDLE
- abort  input  1  cancels an in-progress grid
- grid_x_num  input  GRID_W  cells per row; latched on accepted start
- grid_y_num  input  GRID_W  rows; latched on accepted start
- hcu_enable  output  1  HCU job request; level, held until finish
- gridX_o  output  GRID_W  current cell x coordinate to HCU
- gridY_o  output  GRID_W  current cell y coordinate to HCU
- hcu_finish  input  1  HCU job complete; one-cycle pulse
- cell_valid  output  1  one-cycle pulse per completed cell
- cell_index  output  IDX_W  linear index y*nx+x of the completed cell; valid with cell_valid
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse after the last cell completes
- aborted  output  1  one-cycle pulse acknowledging abort

Behaviour:
- Reset: rst low asynchronously forces state IDLE. All outputs, counters and latched sizes go to 0.
- All outputs are registered.
- Size latch: nx/ny are taken from grid_x_num/grid_y_num on the accepted start. A value of 0 is latched as 1. Later changes to the inputs are ignored until the next start.
- States: IDLE, RUN, GAP, DONE.
- IDLE:
  - On start=1 and abort=0: latch sizes, set x=y=0 and the internal index to 0, go to RUN.
  - hcu_enable=1 from the next cycle.
- RUN:
  - hcu_enable=1; gridX_o/gridY_o hold x/y and are stable for the whole job.
  - On hcu_finish=1: next cycle hcu_enable=0, cell_valid=1, cell_index = current index.
  - If this was the last cell (x=nx-1, y=ny-1), go to DONE.
  - Otherwise go to GAP and advance: x+1, or x=0 and y+1 when x=nx-1; index+1.
- GAP:
  - One-cycle enable-low gap; go to RUN, re-asserting hcu_enable with the new coordinates.
- DONE:
  - Assert done for one cycle (the cycle after the last cell_valid), then return to IDLE.
  - busy falls in the same cycle done is high.
- Timing: start at cycle 0 gives hcu_enable at cycle 1. hcu_finish at cycle k gives cell_valid and hcu_enable=0 at k+1, and the next hcu_enable at k+2.
- Index generation: cell_index uses an incrementing counter, not a multiplier. Maximum is 15*15-1 = 224.
- hcu_finish is ignored when hcu_enable=0 (IDLE, GAP, DONE).
- start while busy is ignored; there is no queuing.
- abort:
  - In RUN, GAP or DONE, next cycle: hcu_enable=0, aborted=1, state=IDLE. No cell_valid or done is produced.
  - abort in IDLE is ignored and produces no aborted pulse.
  - abort together with start in IDLE: start is ignored.
  - abort together with hcu_finish: abort wins and no cell_valid is produced.
- Reset mid-operation drops hcu_enable immediately, asynchronously. No outputs follow until the next start.
- Grid of 1×1: a single job; done follows one cycle after cell_valid.

Test Plan:
- Reset, then start with nx=3, ny=2, HCU finishing 4 cycles after each enable:
  - cell_valid indices 0..5, coordinates (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - hcu_enable low exactly 1 cycle between jobs; done exactly once, 1 cycle after index 5; busy then 0.
- Start with nx=0, ny=0: treated as 1×1; one job at (0,0) with cell_index 0, then done.
- Start with nx=15, ny=15 and immediate-finish HCU: 225 cell_valid pulses, last index 224, then done; cell_index never wraps.
- Assert abort during the third job, together with hcu_finish:
  - No cell_valid for that job; aborted=1 the next cycle, hcu_enable=0, busy=0; no done.
  - A subsequent start restarts at (0,0).
- Pulse start mid-grid, and pulse hcu_finish while in GAP/IDLE: no effect on sequence, counts or outputs.
- Drive rst low while hcu_enable=1: all outputs 0 asynchronously. After release, no activity until a new start.
